alu_arbiter: RTL and testbench

Sequencer and round-robin arbiter that shares one 16-bit ALU adder between two requesters. Each requester issues ADD, SUB or NEG commands over a valid/ready handshake. The block drives the shared adder's operands, and builds subtraction from two adder passes, because the adder has no carry-in. It then returns result and flags on a single response channel tagged with the requester ID. It sits between the two client datapaths and the ALU instance.

---
 rtl/alu_arbiter.sv | 170 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sequencer that shares one carry-less 16-bit adder
// between two requesters. ADD uses one adder pass. NEG uses one pass (~b + 1).
// SUB uses two passes: first -b, then a + (-b). The result and flags are
// returned on a single response channel tagged with the requester id.
module alu_arbiter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [1:0]   req0_op,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [1:0]   req1_op,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   input  logic [W-1:0] alu_c,
   input  logic         alu_sign,
   input  logic         alu_zero,
   input  logic         alu_parity,
   input  logic         alu_carry,
   input  logic         alu_overflow,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [W-1:0] rsp_data,
   output logic [4:0]   rsp_flags,
   output logic         busy
);

   typedef enum logic [1:0] {S_IDLE, S_NEG, S_EXEC, S_RESP} state_t;

   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_NEG = 2'b10;
   localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

   state_t         state_q;
   logic           id_q;
   logic           last_id_q;
   logic [1:0]     op_q;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic [W-1:0]   tmp_q;
   logic           rsp_valid_q;
   logic           busy_q;
   logic [W-1:0]   rsp_data_q;
   logic [4:0]     rsp_flags_q;

   logic           any_valid;
   logic           grant_d;
   logic [1:0]     op_d;
   logic [W-1:0]   a_d;
   logic [W-1:0]   b_d;
   logic [4:0]     flags_d;

   assign any_valid = req0_valid | req1_valid;
   assign flags_d   = {alu_overflow, alu_carry, alu_parity, alu_zero, alu_sign};

   // Pick the requester to serve: a lone requester wins, a tie goes to the one not served last.
   always_comb begin
      grant_d = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_d = ~last_id_q;
      end else if (req1_valid) begin
         grant_d = 1'b1;
      end
      op_d = grant_d ? req1_op : req0_op;
      a_d  = grant_d ? req1_a  : req0_a;
      b_d  = grant_d ? req1_b  : req0_b;
   end

   assign req0_ready = (state_q == S_IDLE) & any_valid & ~grant_d;
   assign req1_ready = (state_q == S_IDLE) & any_valid &  grant_d;

   // Drive the shared adder: ~b + 1 in the negate pass, a + b or a + (-b) in the exec pass.
   always_comb begin
      alu_a = '0;
      alu_b = '0;
      case (state_q)
         S_NEG: begin
            alu_a = ~b_q;
            alu_b = ONE;
         end
         S_EXEC: begin
            alu_a = a_q;
            alu_b = (op_q == OP_SUB) ? tmp_q : b_q;
         end
         default: begin
            alu_a = '0;
            alu_b = '0;
         end
      endcase
   end

   // Command sequencer: accept, run one or two adder passes, hold the response until taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         id_q        <= 1'b0;
         last_id_q   <= 1'b1;
         op_q        <= 2'b00;
         a_q         <= '0;
         b_q         <= '0;
         tmp_q       <= '0;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         rsp_data_q  <= '0;
         rsp_flags_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (any_valid) begin
                  id_q      <= grant_d;
                  last_id_q <= grant_d;
                  op_q      <= op_d;
                  a_q       <= a_d;
                  b_q       <= b_d;
                  busy_q    <= 1'b1;
                  if (op_d == OP_SUB || op_d == OP_NEG) begin
                     state_q <= S_NEG;
                  end else begin
                     state_q <= S_EXEC;
                  end
               end
            end
            S_NEG: begin
               tmp_q <= alu_c;
               if (op_q == OP_NEG) begin
                  rsp_data_q  <= alu_c;
                  rsp_flags_q <= flags_d;
                  rsp_valid_q <= 1'b1;
                  state_q     <= S_RESP;
               end else begin
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               rsp_data_q  <= alu_c;
               rsp_flags_q <= flags_d;
               rsp_valid_q <= 1'b1;
               state_q     <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               rsp_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_flags = rsp_flags_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: behavioural adder, random and directed stimulus,
// and a scoreboard monitor that checks arbitration, busy, latency and responses.
module tb_alu_arbiter;

   logic        clk;
   logic        rst_n;
   logic [1:0]  vld;
   logic        req0_ready, req1_ready;
   logic [1:0]  op_in [2];
   logic [15:0] a_in [2];
   logic [15:0] b_in [2];
   logic [15:0] alu_a, alu_b, alu_c;
   logic        alu_sign, alu_zero, alu_parity, alu_carry, alu_overflow;
   logic        rsp_valid, rsp_ready, rsp_id, busy;
   logic [15:0] rsp_data;
   logic [4:0]  rsp_flags;
   logic [16:0] alu_s;

   alu_arbiter #(.W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(vld[0]), .req0_ready(req0_ready), .req0_op(op_in[0]),
      .req0_a(a_in[0]), .req0_b(b_in[0]),
      .req1_valid(vld[1]), .req1_ready(req1_ready), .req1_op(op_in[1]),
      .req1_a(a_in[1]), .req1_b(b_in[1]),
      .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
      .alu_sign(alu_sign), .alu_zero(alu_zero), .alu_parity(alu_parity),
      .alu_carry(alu_carry), .alu_overflow(alu_overflow),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_flags(rsp_flags), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared adder with flags (even parity: 1 when the sum has an even number of ones).
   always_comb begin
      alu_s        = {1'b0, alu_a} + {1'b0, alu_b};
      alu_c        = alu_s[15:0];
      alu_carry    = alu_s[16];
      alu_sign     = alu_s[15];
      alu_zero     = (alu_s[15:0] == 16'h0000);
      alu_parity   = ~^alu_s[15:0];
      alu_overflow = (alu_a[15] == alu_b[15]) && (alu_s[15] != alu_a[15]);
   end

   typedef struct {
      bit          id;
      logic [15:0] data;
      logic [4:0]  flags;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   bit   last_id = 1'b1;
   logic [1:0] acc = 2'b00;
   logic [1:0] exp_rdy;
   bit   g;
   bit   exp_v;
   exp_t e;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: result from plain modular arithmetic, flags from the final adder pass.
   function automatic exp_t ref_model(bit id, logic [1:0] op, logic [15:0] a,
                                      logic [15:0] b, int acc_cyc);
      exp_t r;
      int unsigned ai, bi, x, y, d;
      int sx, sy, lat;
      logic [15:0] dv;
      ai = a;
      bi = b;
      case (op)
         2'b01: begin
            d = (ai + 65536 - bi) % 65536; x = ai; y = (65536 - bi) % 65536; lat = 3;
         end
         2'b10: begin
            d = (65536 - bi) % 65536; x = 65535 - bi; y = 1; lat = 2;
         end
         default: begin
            d = (ai + bi) % 65536; x = ai; y = bi; lat = 2;
         end
      endcase
      sx = (x >= 32768) ? int'(x) - 65536 : int'(x);
      sy = (y >= 32768) ? int'(y) - 65536 : int'(y);
      dv = d[15:0];
      r.id    = id;
      r.data  = dv;
      r.flags = {((sx + sy) > 32767) || ((sx + sy) < -32768),
                 (x + y) >= 65536,
                 ($countones(dv) % 2) == 0,
                 d == 0,
                 d >= 32768};
      r.due   = acc_cyc + lat;
      return r;
   endfunction

   // Monitor: arbitration, busy, response timing and content, expected-response push.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         last_id = 1'b1;
         acc = 2'b00;
      end else begin
         cyc++;
         chk("busy", {31'd0, busy}, {31'd0, sb.size() != 0});
         exp_rdy = 2'b00;
         if (sb.size() == 0 && vld != 2'b00) begin
            g = (vld == 2'b11) ? ~last_id : vld[1];
            exp_rdy[g] = 1'b1;
         end
         chk("ready", {30'd0, req1_ready, req0_ready}, {30'd0, exp_rdy});
         acc = vld & {req1_ready, req0_ready};
         exp_v = (sb.size() != 0) && (sb[0].due == cyc);
         chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_v});
         if (exp_v) begin
            e = sb.pop_front();
            if (rsp_valid) begin
               chk("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
               chk("rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
               chk("rsp_flags", {27'd0, rsp_flags}, {27'd0, e.flags});
               if (!rsp_ready) begin
                  e.due = cyc + 1;
                  sb.push_front(e);
               end
            end
         end
         if (acc != 2'b00) begin
            g = acc[1];
            sb.push_back(ref_model(g, op_in[g], a_in[g], b_in[g], cyc));
            last_id = g;
         end
      end
   end

   function automatic logic [15:0] rnd_opnd();
      case ($urandom_range(7))
         0: return 16'h0000;
         1: return 16'h7FFF;
         2: return 16'h8000;
         3: return 16'hFFFF;
         4: return 16'h0001;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic drive_cycle(input int pct, input int rdy_pct);
      @(posedge clk); #1;
      for (int n = 0; n < 2; n++) begin
         if (!vld[n] || acc[n]) begin
            vld[n]   = ($urandom_range(99) < pct);
            op_in[n] = 2'($urandom_range(3));
            a_in[n]  = rnd_opnd();
            b_in[n]  = rnd_opnd();
         end else if (pct < 100 && $urandom_range(15) == 0) begin
            vld[n] = 1'b0;
         end
      end
      rsp_ready = ($urandom_range(99) < rdy_pct);
   endtask

   task automatic issue(input bit id, input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b);
      bit ok;
      @(posedge clk); #1;
      vld       = 2'b00;
      vld[id]   = 1'b1;
      op_in[id] = op;
      a_in[id]  = a;
      b_in[id]  = b;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(posedge clk); #1;
         ok = acc[id];
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
      vld[id] = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(posedge clk); #1;
         ok = (sb.size() == 0);
      end
      if (!ok) chk("drain_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      vld       = 2'b00;
      rsp_ready = 1'b1;
      for (int n = 0; n < 2; n++) begin
         op_in[n] = 2'b00;
         a_in[n]  = 16'h0000;
         b_in[n]  = 16'h0000;
      end
      #1;
      chk("reset_outputs", {26'd0, rsp_valid, busy, req0_ready, req1_ready, rsp_id, |rsp_flags},
          32'd0);
      chk("reset_data", {rsp_data, alu_a | alu_b}, 32'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // Directed corner commands.
      issue(1'b0, 2'b00, 16'h7FFF, 16'h0001); wait_idle();
      issue(1'b1, 2'b00, 16'hFFFF, 16'h0001); wait_idle();
      issue(1'b1, 2'b10, 16'h0000, 16'h8000); wait_idle();
      issue(1'b0, 2'b01, 16'h0005, 16'h0003); wait_idle();
      issue(1'b0, 2'b01, 16'h1234, 16'h8000); wait_idle();
      issue(1'b1, 2'b11, 16'h8000, 16'h8000); wait_idle();
      issue(1'b0, 2'b10, 16'h0000, 16'h0000); wait_idle();

      // Response backpressure held for several cycles.
      rsp_ready = 1'b0;
      issue(1'b0, 2'b00, 16'h1234, 16'h4321);
      repeat (6) @(posedge clk);
      #1 rsp_ready = 1'b1;
      wait_idle();

      // Random traffic with occasional drops and backpressure.
      for (int i = 0; i < 400; i++) drive_cycle(70, 75);
      vld = 2'b00;
      rsp_ready = 1'b1;
      wait_idle();

      // Reset during the exec pass of a SUB.
      issue(1'b0, 2'b01, 16'h0005, 16'h0003);
      chk("neg_alu_a", {16'd0, alu_a}, 32'h0000FFFC);
      chk("neg_alu_b", {16'd0, alu_b}, 32'h00000001);
      @(posedge clk); #1;
      chk("exec_alu_a", {16'd0, alu_a}, 32'h00000005);
      chk("exec_alu_b", {16'd0, alu_b}, 32'h0000FFFD);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_outputs", {26'd0, rsp_valid, busy, req0_ready, req1_ready, rsp_id,
          |rsp_flags}, 32'd0);
      chk("async_rst_data", {rsp_data, alu_a | alu_b}, 32'd0);
      @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (3) @(posedge clk);

      // Both requesters valid continuously: grants must alternate starting with req0.
      for (int i = 0; i < 40; i++) drive_cycle(100, 100);
      for (int i = 0; i < 40; i++) drive_cycle(100, 60);
      vld = 2'b00;
      rsp_ready = 1'b1;
      wait_idle();
      repeat (3) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
